adc_sample_averager: RTL

//   Downstream of the MCP3008 interface. Takes 16-bit ADC words on its avail/accept handshake.

---
 rtl/adc_sample_averager_pkg.sv | 14 +
 rtl/adc_sample_averager.sv | 139 +++++++++++++
 2 files changed

// File: rtl/adc_sample_averager_pkg.sv
// Shared widths and FSM state encoding for the ADC sample averager.
package adc_sample_averager_pkg;

    localparam int ADC_WORD_W   = 16;
    localparam int MCP3008_BITS = 10;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_ACK    = 2'd1,
        ST_WAITLO = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

endpackage

// File: rtl/adc_sample_averager.sv
// Averages 2**LOG2_N ADC samples taken on an avail/accept handshake and offers the result on valid/ready.
// Build option: define AVG_ROUND_EN for round-half-up averaging (default truncates).
//
// state  | meaning
// ACCUM  | waiting for adc_avail; capture sample into running sum
// ACK    | accept pulse out; emit average if the block is complete
// WAITLO | wait for adc_avail to drop so one word is never counted twice
// OUT    | average held on out_data until out_ready; upstream stalled
module adc_sample_averager
    import adc_sample_averager_pkg::*;
#(
    parameter int DATA_W = MCP3008_BITS,
    parameter int LOG2_N = 2,
    parameter int OUT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [ADC_WORD_W-1:0] adc_data,
    input  logic                  adc_avail,
    output logic                  adc_accept,
    output logic [OUT_W-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int SUM_W = DATA_W + LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << LOG2_N);
    localparam logic [SUM_W:0]   AVG_MAX  = (SUM_W + 1)'((1 << DATA_W) - 1);

    state_t                r_state;
    logic [SUM_W-1:0]      r_sum;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_accept;
    logic [OUT_W-1:0]      r_out_data;
    logic                  r_out_valid;

    state_t                w_state_nxt;
    logic [SUM_W-1:0]      w_sum_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_accept_nxt;
    logic [OUT_W-1:0]      w_out_data_nxt;
    logic                  w_out_valid_nxt;

    logic [SUM_W:0]        w_wide;
    logic [DATA_W-1:0]     w_avg;
    logic                  w_unused_hi;

    // Bits above DATA_W carry no information from the converter.
    assign w_unused_hi = ^adc_data;

`ifdef AVG_ROUND_EN
    localparam int HALF = (1 << LOG2_N) >> 1;
    assign w_wide = ({1'b0, r_sum} + (SUM_W + 1)'(HALF)) >> LOG2_N;
`else
    assign w_wide = {1'b0, r_sum} >> LOG2_N;
`endif

    assign w_avg = (w_wide > AVG_MAX) ? DATA_W'(AVG_MAX) : w_wide[DATA_W-1:0];

    always_comb begin
        w_state_nxt     = r_state;
        w_sum_nxt       = r_sum;
        w_cnt_nxt       = r_cnt;
        w_accept_nxt    = 1'b0;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;

        case (r_state)
            ST_ACCUM: begin
                if (adc_avail) begin
                    w_sum_nxt    = r_sum + SUM_W'(adc_data[DATA_W-1:0]);
                    w_cnt_nxt    = r_cnt + CNT_W'(1);
                    w_accept_nxt = 1'b1;
                    w_state_nxt  = ST_ACK;
                end
            end
            ST_ACK: begin
                if (r_cnt == CNT_FULL) begin
                    w_out_data_nxt  = OUT_W'(w_avg);
                    w_out_valid_nxt = 1'b1;
                    w_sum_nxt       = '0;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = ST_OUT;
                end else begin
                    w_state_nxt = ST_WAITLO;
                end
            end
            ST_WAITLO: begin
                if (!adc_avail) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = ST_WAITLO;
                end
            end
            default: w_state_nxt = ST_ACCUM;
        endcase

        // A finished average is never discarded, so clear has no effect in OUT.
        if (clear && (r_state != ST_OUT)) begin
            w_sum_nxt       = '0;
            w_cnt_nxt       = '0;
            w_accept_nxt    = 1'b0;
            w_out_data_nxt  = r_out_data;
            w_out_valid_nxt = r_out_valid;
            w_state_nxt     = adc_avail ? ST_WAITLO : ST_ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_ACCUM;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_accept    <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sum       <= w_sum_nxt;
            r_cnt       <= w_cnt_nxt;
            r_accept    <= w_accept_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign adc_accept = r_accept;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign busy       = (r_state != ST_ACCUM) || (r_cnt != '0);

endmodule
